// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for a 4-master shared bus. The grant lines are registered
// and one-hot-low. A grant stays with its owner while the owner requests, with an optional hold limit.
module bus_arbiter_rr #(
  parameter int HOLD_MAX = 16,
  parameter int HOLD_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_n,
  input  logic              m1_req_n,
  input  logic              m2_req_n,
  input  logic              m3_req_n,
  output logic              m0_grnt_n,
  output logic              m1_grnt_n,
  output logic              m2_grnt_n,
  output logic              m3_grnt_n,
  output logic [1:0]        owner,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [HOLD_W-1:0] CNT_SAT   = {HOLD_W{1'b1}};

  logic [3:0]        req;
  logic [3:0]        owner_onehot;
  logic              own_req;
  logic              pend;
  logic [1:0]        next_owner;
  logic              next_found;
  logic [1:0]        owner_q, owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        grnt_n_q, grnt_n_d;

  assign req          = ~{m3_req_n, m2_req_n, m1_req_n, m0_req_n};
  assign owner_onehot = 4'b0001 << owner_q;
  assign own_req      = |(req & owner_onehot);
  assign pend         = |(req & ~owner_onehot);

  // Rotating search that starts one past the current owner. The owner is never a candidate.
  always_comb begin
    next_owner = owner_q;
    next_found = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (!next_found && req[owner_q + 2'(k)]) begin
        next_owner = owner_q + 2'(k);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    owner_d    = owner_q;
    hold_cnt_d = '0;
    if (own_req && pend) begin
      if (HOLD_MAX == 0) begin
        hold_cnt_d = (hold_cnt_q == CNT_SAT) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
      end else if (hold_cnt_q < HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end else begin
        owner_d = next_owner;
      end
    end else if (!own_req && pend) begin
      owner_d = next_owner;
    end
  end

  // Grant flops load the decode of the next owner, so they always agree with owner_q.
  for (genvar gi = 0; gi < 4; gi++) begin : g_grnt_decode
    assign grnt_n_d[gi] = (owner_d != 2'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= 2'd0;
      hold_cnt_q <= '0;
      grnt_n_q   <= 4'b1110;
    end else begin
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      grnt_n_q   <= grnt_n_d;
    end
  end

  assign owner     = owner_q;
  assign hold_cnt  = hold_cnt_q;
  assign m0_grnt_n = grnt_n_q[0];
  assign m1_grnt_n = grnt_n_q[1];
  assign m2_grnt_n = grnt_n_q[2];
  assign m3_grnt_n = grnt_n_q[3];

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr. It runs directed scenarios and then random traffic. Two instances are checked:
// one with a hold limit of 4, and one with no limit and a 3-bit counter to exercise saturation.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_n = 4'b1111;

  logic       a_g0, a_g1, a_g2, a_g3;
  logic [1:0] a_owner;
  logic [7:0] a_hold;
  logic       b_g0, b_g1, b_g2, b_g3;
  logic [1:0] b_owner;
  logic [2:0] b_hold;
  logic [3:0] a_grnt, b_grnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference-model state for both instances.
  int a_mo = 0, a_mc = 0;
  int b_mo = 0, b_mc = 0;

  assign a_grnt = {a_g3, a_g2, a_g1, a_g0};
  assign b_grnt = {b_g3, b_g2, b_g1, b_g0};

  always #5 clk = ~clk;

  bus_arbiter_rr #(.HOLD_MAX(4), .HOLD_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req_n(req_n[0]), .m1_req_n(req_n[1]), .m2_req_n(req_n[2]), .m3_req_n(req_n[3]),
    .m0_grnt_n(a_g0), .m1_grnt_n(a_g1), .m2_grnt_n(a_g2), .m3_grnt_n(a_g3),
    .owner(a_owner), .hold_cnt(a_hold)
  );

  bus_arbiter_rr #(.HOLD_MAX(0), .HOLD_W(3)) dut_nl (
    .clk(clk), .reset(reset),
    .m0_req_n(req_n[0]), .m1_req_n(req_n[1]), .m2_req_n(req_n[2]), .m3_req_n(req_n[3]),
    .m0_grnt_n(b_g0), .m1_grnt_n(b_g1), .m2_grnt_n(b_g2), .m3_grnt_n(b_g3),
    .owner(b_owner), .hold_cnt(b_hold)
  );

  // Arbitration rules written directly with modular arithmetic over master indices.
  function automatic void arb_model(input int own, input int cnt, input logic [3:0] req,
                                    input logic rst, input int hmax, input int cmax,
                                    output int nown, output int ncnt);
    int first;
    first = -1;
    for (int k = 1; k <= 3; k++)
      if (first < 0 && req[(own + k) % 4]) first = (own + k) % 4;
    if (rst) begin
      nown = 0; ncnt = 0;
    end else if (!req[own]) begin
      nown = (first >= 0) ? first : own; ncnt = 0;
    end else if (first < 0) begin
      nown = own; ncnt = 0;
    end else if (hmax == 0) begin
      nown = own; ncnt = (cnt < cmax) ? cnt + 1 : cmax;
    end else if (cnt + 1 < hmax) begin
      nown = own; ncnt = cnt + 1;
    end else begin
      nown = first; ncnt = 0;
    end
  endfunction

  // One clock: advance both models with the inputs now applied, then settle past the edge.
  task automatic tick();
    int no, nc;
    arb_model(a_mo, a_mc, ~req_n, reset, 4, 255, no, nc);
    a_mo = no; a_mc = nc;
    arb_model(b_mo, b_mc, ~req_n, reset, 0, 7, no, nc);
    b_mo = no; b_mc = nc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_n = 4'b1111;
    tick(); tick();
    n_checks++;
    if (a_owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner got %0d want 0", a_owner); end
    n_checks++;
    if (a_grnt !== 4'b1110) begin n_fail++; $display("FAIL reset_grnt got %b want 1110", a_grnt); end
    n_checks++;
    if (a_hold !== 8'd0) begin n_fail++; $display("FAIL reset_hold got %0d want 0", a_hold); end
    n_checks++;
    if (b_grnt !== 4'b1110 || b_owner !== 2'd0) begin
      n_fail++; $display("FAIL reset_nl got grnt=%b owner=%0d want 1110/0", b_grnt, b_owner);
    end
    reset = 1'b0;
    $display("test_reset: owner=%0d grnt=%b hold=%0d", a_owner, a_grnt, a_hold);
  endtask

  task automatic test_single_req();
    req_n = 4'b1011;
    tick();
    n_checks++;
    if (a_owner !== 2'd2 || a_grnt !== 4'b1011) begin
      n_fail++; $display("FAIL single_grant got owner=%0d grnt=%b want 2/1011", a_owner, a_grnt);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (a_owner !== 2'd2 || a_grnt !== 4'b1011 || a_hold !== 8'd0) begin
        n_fail++;
        $display("FAIL single_sticky cyc %0d got owner=%0d grnt=%b hold=%0d want 2/1011/0",
                 i, a_owner, a_grnt, a_hold);
      end
    end
    $display("test_single_req: owner=%0d grnt=%b", a_owner, a_grnt);
  endtask

  task automatic test_rotation();
    logic [3:0] pat  [4];
    logic [1:0] want [4];
    pat[0] = 4'b0111; want[0] = 2'd3;  // m2 releases, m3 waiting
    pat[1] = 4'b1000; want[1] = 2'd0;  // m3 releases, m0/m1/m2 request
    pat[2] = 4'b1001; want[2] = 2'd1;  // m0 releases
    pat[3] = 4'b1011; want[3] = 2'd2;  // m1 releases
    for (int i = 0; i < 4; i++) begin
      req_n = pat[i];
      tick();
      n_checks++;
      if (a_owner !== want[i] || a_grnt !== ~(4'b0001 << want[i])) begin
        n_fail++;
        $display("FAIL rotation step %0d got owner=%0d grnt=%b want owner=%0d", i, a_owner, a_grnt, want[i]);
      end
      $display("test_rotation: req_n=%b owner=%0d", pat[i], a_owner);
    end
  endtask

  task automatic test_park();
    req_n = 4'b1101;
    tick();
    n_checks++;
    if (a_owner !== 2'd1) begin n_fail++; $display("FAIL park_setup got owner=%0d want 1", a_owner); end
    req_n = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (a_owner !== 2'd1 || a_grnt !== 4'b1101 || a_hold !== 8'd0) begin
        n_fail++;
        $display("FAIL park cyc %0d got owner=%0d grnt=%b hold=%0d want 1/1101/0", i, a_owner, a_grnt, a_hold);
      end
    end
    $display("test_park: owner=%0d grnt=%b", a_owner, a_grnt);
  endtask

  task automatic test_hold_limit();
    req_n = 4'b1110;
    tick();
    n_checks++;
    if (a_owner !== 2'd0) begin n_fail++; $display("FAIL hold_setup got owner=%0d want 0", a_owner); end
    req_n = 4'b1100;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (a_owner !== 2'd0 || a_hold !== 8'(i)) begin
        n_fail++; $display("FAIL hold_count got owner=%0d hold=%0d want 0/%0d", a_owner, a_hold, i);
      end
    end
    tick();
    n_checks++;
    if (a_owner !== 2'd1 || a_hold !== 8'd0 || a_grnt !== 4'b1101) begin
      n_fail++;
      $display("FAIL hold_force got owner=%0d hold=%0d grnt=%b want 1/0/1101", a_owner, a_hold, a_grnt);
    end
    // The unlimited instance keeps m0 and its counter must pin at 7.
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (b_owner !== 2'd0 || b_hold !== 3'd7) begin
      n_fail++; $display("FAIL hold_saturate got owner=%0d hold=%0d want 0/7", b_owner, b_hold);
    end
    $display("test_hold_limit: owner=%0d hold=%0d nl_hold=%0d", a_owner, a_hold, b_hold);
  endtask

  task automatic test_reset_mid();
    req_n = 4'b1011;
    tick(); tick();
    n_checks++;
    if (a_owner !== 2'd2) begin n_fail++; $display("FAIL midreset_setup got owner=%0d want 2", a_owner); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (a_owner !== 2'd0 || a_grnt !== 4'b1110 || a_hold !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset got owner=%0d grnt=%b hold=%0d want 0/1110/0", a_owner, a_grnt, a_hold);
    end
    $display("test_reset_mid: owner=%0d grnt=%b", a_owner, a_grnt);
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      req_n = 4'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick();
      n_checks++;
      if (a_owner !== 2'(a_mo) || a_hold !== 8'(a_mc) || a_grnt !== ~(4'b0001 << a_mo)) begin
        n_fail++; bad++;
        $display("FAIL random_lim cyc %0d got owner=%0d hold=%0d grnt=%b want owner=%0d hold=%0d",
                 i, a_owner, a_hold, a_grnt, a_mo, a_mc);
      end
      n_checks++;
      if (b_owner !== 2'(b_mo) || b_hold !== 3'(b_mc) || b_grnt !== ~(4'b0001 << b_mo)) begin
        n_fail++; bad++;
        $display("FAIL random_nolim cyc %0d got owner=%0d hold=%0d grnt=%b want owner=%0d hold=%0d",
                 i, b_owner, b_hold, b_grnt, b_mo, b_mc);
      end
      n_checks++;
      if ($countones(~a_grnt) != 1 || $countones(~b_grnt) != 1) begin
        n_fail++; bad++;
        $display("FAIL onehot_low cyc %0d got grnt=%b/%b want exactly one low", i, a_grnt, b_grnt);
      end
    end
    reset = 1'b0;
    $display("test_random: 10000 cycles, %0d mismatching checks", bad);
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_rotation();
    test_park();
    test_hold_limit();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
